mem_lsu: RTL and testbench

Parametrised load/store MEM stage between EX and WB of the RISC-V core. Stages EX results, posts stores into an in-order store buffer, runs a request/grant/rvalid handshake with the memory controller, and performs byte-lane selection with sign/zero extension. Replaces the combinational MEM stage with a clocked, stall-correct stage that supports RV32 or RV64 and detects misaligned accesses.

---
 rtl/mem_lsu_if.sv | 25 ++
 rtl/mem_lsu.sv | 213 +++++++++++++++++++++
 tb/tb_mem_lsu.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_lsu_if.sv
// Memory-controller port of the load/store stage: request/grant/rvalid handshake.
interface mem_lsu_if #(
  parameter int unsigned XLEN = 32
);
  localparam int unsigned BE_W = XLEN / 8;

  logic            mem_req;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [BE_W-1:0] mem_be;
  logic            mem_gnt;
  logic            mem_rvalid;
  logic [XLEN-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/mem_lsu.sv
// Clocked MEM stage: in-order store buffer, single outstanding load, lane select and
// sign/zero extension, misalignment/illegal-op detection.
module mem_lsu #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned SB_DEPTH = 2,
  parameter int unsigned REG_W    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  input  logic [3:0]       ex_op,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_wreg,
  input  logic [XLEN-1:0]  ex_addr,
  input  logic [XLEN-1:0]  ex_wdata,
  output logic             ex_ready,
  output logic             stall_req,
  mem_lsu_if.master        mem,
  output logic             fwd_valid,
  output logic [REG_W-1:0] fwd_rd,
  output logic [XLEN-1:0]  fwd_data,
  output logic             wb_valid,
  output logic [REG_W-1:0] wb_rd,
  output logic             wb_wreg,
  output logic [XLEN-1:0]  wb_data,
  output logic             err_o,
  output logic [XLEN-1:0]  err_addr
);
  localparam int unsigned BE_W  = XLEN / 8;
  localparam int unsigned OFF_W = $clog2(BE_W);
  localparam int unsigned PTR_W = (SB_DEPTH > 1) ? $clog2(SB_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(SB_DEPTH + 1);

  localparam logic [3:0] OP_LB = 4'd1, OP_LH = 4'd2, OP_LW = 4'd3, OP_LBU = 4'd4,
                         OP_LHU = 4'd5, OP_LD = 4'd6, OP_LWU = 4'd7, OP_SB = 4'd9,
                         OP_SH = 4'd10, OP_SW = 4'd11, OP_SD = 4'd12;

  localparam logic [1:0] S_IDLE = 2'd0, S_LD_PEND = 2'd1, S_LD_REQ = 2'd2, S_LD_WAIT = 2'd3;

  logic [1:0]       state, state_nx;
  logic             is_load, is_store, illegal, misal, bad, accept, push, pop, drain, sb_full;
  logic [1:0]       size_lg;
  logic [OFF_W-1:0] off, ld_off;
  logic [BE_W-1:0]  be_mask;
  logic [XLEN-1:0]  ld_shift, ld_data;

  logic [XLEN-1:0]  sb_addr [SB_DEPTH];
  logic [XLEN-1:0]  sb_data [SB_DEPTH];
  logic [BE_W-1:0]  sb_be   [SB_DEPTH];
  logic [PTR_W-1:0] sb_head, sb_tail;
  logic [CNT_W-1:0] sb_count;

  logic [3:0]       ld_op;
  logic [REG_W-1:0] ld_rd;
  logic             ld_wreg;
  logic [XLEN-1:0]  ld_addr;

  // Op decode: class, access size (log2 bytes) and fault detection
  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    size_lg  = 2'd0;
    case (ex_op)
      OP_LB, OP_LBU: begin is_load  = 1'b1; size_lg = 2'd0; end
      OP_LH, OP_LHU: begin is_load  = 1'b1; size_lg = 2'd1; end
      OP_LW, OP_LWU: begin is_load  = 1'b1; size_lg = 2'd2; end
      OP_LD:         begin is_load  = 1'b1; size_lg = 2'd3; end
      OP_SB:         begin is_store = 1'b1; size_lg = 2'd0; end
      OP_SH:         begin is_store = 1'b1; size_lg = 2'd1; end
      OP_SW:         begin is_store = 1'b1; size_lg = 2'd2; end
      OP_SD:         begin is_store = 1'b1; size_lg = 2'd3; end
      default: ;
    endcase
    off     = ex_addr[OFF_W-1:0];
    illegal = (XLEN == 32) && (ex_op == OP_LD || ex_op == OP_LWU || ex_op == OP_SD);
    misal   = (off & OFF_W'((4'd1 << size_lg) - 4'd1)) != '0;
    bad     = (is_load || is_store) && (illegal || misal);
    case (size_lg)
      2'd0:    be_mask = BE_W'(4'h1);
      2'd1:    be_mask = BE_W'(4'h3);
      2'd2:    be_mask = BE_W'(4'hF);
      default: be_mask = '1;
    endcase
  end

  assign sb_full   = sb_count == CNT_W'(SB_DEPTH);
  assign ex_ready  = (state == S_IDLE) && !(is_store && sb_full);
  assign stall_req = ex_valid && !ex_ready;
  assign accept    = ex_valid && ex_ready;
  assign push      = accept && is_store && !bad;
  assign drain     = (state == S_IDLE || state == S_LD_PEND) && sb_count != '0;
  assign pop       = drain && mem.mem_gnt;

  assign fwd_valid = accept && ex_wreg && !is_load && ex_rd != '0;
  assign fwd_rd    = ex_rd;
  assign fwd_data  = ex_wdata;

  // Store buffer storage; occupancy tracked by pointers/count below
  always_ff @(posedge clk) begin
    if (push) begin
      sb_addr[sb_tail] <= {ex_addr[XLEN-1:OFF_W], OFF_W'(0)};
      sb_data[sb_tail] <= ex_wdata << {off, 3'b000};
      sb_be[sb_tail]   <= be_mask << off;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sb_head  <= '0;
      sb_tail  <= '0;
      sb_count <= '0;
    end else begin
      if (push) sb_tail <= (sb_tail == PTR_W'(SB_DEPTH - 1)) ? '0 : sb_tail + PTR_W'(1);
      if (pop)  sb_head <= (sb_head == PTR_W'(SB_DEPTH - 1)) ? '0 : sb_head + PTR_W'(1);
      sb_count <= sb_count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Load slot holds the accepted load until it retires
  always_ff @(posedge clk) begin
    if (rst) begin
      ld_op   <= '0;
      ld_rd   <= '0;
      ld_wreg <= 1'b0;
      ld_addr <= '0;
    end else if (accept && is_load && !bad) begin
      ld_op   <= ex_op;
      ld_rd   <= ex_rd;
      ld_wreg <= ex_wreg;
      ld_addr <= ex_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:    if (accept && is_load && !bad) state_nx = S_LD_PEND;
      S_LD_PEND: if (sb_count == '0)            state_nx = S_LD_REQ;
      S_LD_REQ:  if (mem.mem_gnt)               state_nx = S_LD_WAIT;
      S_LD_WAIT: if (mem.mem_rvalid)            state_nx = S_IDLE;
      default:                                  state_nx = S_IDLE;
    endcase
  end

  // Bus drive: the load request wins only once the buffer has drained
  always_comb begin
    mem.mem_req   = 1'b0;
    mem.mem_we    = 1'b0;
    mem.mem_addr  = '0;
    mem.mem_wdata = '0;
    mem.mem_be    = '0;
    if (state == S_LD_REQ) begin
      mem.mem_req  = 1'b1;
      mem.mem_addr = {ld_addr[XLEN-1:OFF_W], OFF_W'(0)};
    end else if (drain) begin
      mem.mem_req   = 1'b1;
      mem.mem_we    = 1'b1;
      mem.mem_addr  = sb_addr[sb_head];
      mem.mem_wdata = sb_data[sb_head];
      mem.mem_be    = sb_be[sb_head];
    end
  end

  assign ld_off   = ld_addr[OFF_W-1:0];
  assign ld_shift = mem.mem_rdata >> {ld_off, 3'b000};

  always_comb begin
    case (ld_op)
      OP_LB:   ld_data = XLEN'($signed(ld_shift[7:0]));
      OP_LBU:  ld_data = XLEN'(ld_shift[7:0]);
      OP_LH:   ld_data = XLEN'($signed(ld_shift[15:0]));
      OP_LHU:  ld_data = XLEN'(ld_shift[15:0]);
      OP_LW:   ld_data = XLEN'($signed(ld_shift[31:0]));
      OP_LWU:  ld_data = XLEN'(ld_shift[31:0]);
      default: ld_data = ld_shift;
    endcase
  end

  // WB / error registers: one-cycle pulses per retired instruction
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid <= 1'b0;
      wb_rd    <= '0;
      wb_wreg  <= 1'b0;
      wb_data  <= '0;
      err_o    <= 1'b0;
      err_addr <= '0;
    end else begin
      wb_valid <= 1'b0;
      err_o    <= 1'b0;
      if (state == S_LD_WAIT && mem.mem_rvalid) begin
        wb_valid <= 1'b1;
        wb_rd    <= ld_rd;
        wb_wreg  <= ld_wreg;
        wb_data  <= ld_data;
      end else if (accept && !(is_load && !bad)) begin
        wb_valid <= 1'b1;
        wb_rd    <= ex_rd;
        wb_wreg  <= ex_wreg && !is_load && !is_store;
        wb_data  <= ex_wdata;
        if (bad) begin
          err_o    <= 1'b1;
          err_addr <= ex_addr;
        end
      end
    end
  end
endmodule

// File: tb/tb_mem_lsu.sv
// Directed self-checking bench for mem_lsu (XLEN=32, SB_DEPTH=2).
module tb_mem_lsu;
  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [3:0]  ex_op;
  logic [4:0]  ex_rd;
  logic        ex_wreg;
  logic [31:0] ex_addr;
  logic [31:0] ex_wdata;
  logic        ex_ready, stall_req;
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        wb_wreg;
  logic [31:0] wb_data;
  logic        err_o;
  logic [31:0] err_addr;

  int total = 0;
  int bad   = 0;

  mem_lsu_if #(.XLEN(32)) mem_bus ();

  mem_lsu #(.XLEN(32), .SB_DEPTH(2), .REG_W(5)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_op(ex_op), .ex_rd(ex_rd), .ex_wreg(ex_wreg),
    .ex_addr(ex_addr), .ex_wdata(ex_wdata),
    .ex_ready(ex_ready), .stall_req(stall_req),
    .mem(mem_bus),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_wreg(wb_wreg), .wb_data(wb_data),
    .err_o(err_o), .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [4:0] rd,
                       input logic wr, input logic [31:0] a, input logic [31:0] d);
    ex_valid = v; ex_op = op; ex_rd = rd; ex_wreg = wr; ex_addr = a; ex_wdata = d;
  endtask

  // Waits for the load request, grants it, returns read data one cycle later
  task automatic finish_load(input string tag, input logic [31:0] a, input logic [4:0] rd,
                             input logic [31:0] rdata, input logic [31:0] exp);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      @(negedge clk);
      if (mem_bus.mem_req && !mem_bus.mem_we) found = 1'b1;
    end
    chk({tag, "_req_seen"}, 64'(found), 64'd1);
    if (found) begin
      chk({tag, "_req_addr"}, 64'(mem_bus.mem_addr), 64'(a & 32'hFFFF_FFFC));
      mem_bus.mem_gnt = 1'b1;
      tick();
      mem_bus.mem_gnt    = 1'b0;
      mem_bus.mem_rvalid = 1'b1;
      mem_bus.mem_rdata  = rdata;
      @(negedge clk);
      chk({tag, "_wb_early"}, 64'(wb_valid), 64'd0);
      tick();
      mem_bus.mem_rvalid = 1'b0;
      @(negedge clk);
      chk({tag, "_wb_valid"}, 64'(wb_valid), 64'd1);
      chk({tag, "_wb_data"}, 64'(wb_data), 64'(exp));
      chk({tag, "_wb_rd"}, 64'(wb_rd), 64'(rd));
      tick();
      @(negedge clk);
      chk({tag, "_wb_pulse"}, 64'(wb_valid), 64'd0);
    end
  endtask

  task automatic load_seq(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [4:0] rd, input logic [31:0] rdata,
                          input logic [31:0] exp);
    tick();
    drive(1'b1, op, rd, 1'b1, a, 32'h0);
    @(negedge clk);
    chk({tag, "_ready"}, 64'(ex_ready), 64'd1);
    chk({tag, "_nofwd"}, 64'(fwd_valid), 64'd0);
    tick();
    drive(1'b0, 4'd0, 5'd0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk({tag, "_busy"}, 64'(ex_ready), 64'd0);
    finish_load(tag, a, rd, rdata, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    drive(1'b0, 4'd0, 5'd0, 1'b0, 32'h0, 32'h0);
    mem_bus.mem_gnt = 1'b0; mem_bus.mem_rvalid = 1'b0; mem_bus.mem_rdata = 32'h0;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_ready", 64'(ex_ready), 64'd1);
    chk("rst_wb", 64'(wb_valid), 64'd0);
    chk("rst_req", 64'(mem_bus.mem_req), 64'd0);
    chk("rst_err", 64'(err_o), 64'd0);
    tick();
    rst = 1'b0;

    // ALU result forwarded and written back
    tick();
    drive(1'b1, 4'd0, 5'd5, 1'b1, 32'h0, 32'h1234);
    @(negedge clk);
    chk("add_fwd_valid", 64'(fwd_valid), 64'd1);
    chk("add_fwd_rd", 64'(fwd_rd), 64'd5);
    chk("add_fwd_data", 64'(fwd_data), 64'h1234);
    tick();
    drive(1'b0, 4'd0, 5'd0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("add_wb_valid", 64'(wb_valid), 64'd1);
    chk("add_wb_rd", 64'(wb_rd), 64'd5);
    chk("add_wb_wreg", 64'(wb_wreg), 64'd1);
    chk("add_wb_data", 64'(wb_data), 64'h1234);
    tick();
    drive(1'b1, 4'd0, 5'd0, 1'b1, 32'h0, 32'h55);
    @(negedge clk);
    chk("add_wb_pulse", 64'(wb_valid), 64'd0);
    chk("x0_nofwd", 64'(fwd_valid), 64'd0);

    // SB to an odd byte lane, held until granted
    tick();
    drive(1'b1, 4'd9, 5'd0, 1'b0, 32'h1003, 32'hAB);
    @(negedge clk);
    chk("sb_ready", 64'(ex_ready), 64'd1);
    tick();
    drive(1'b0, 4'd0, 5'd0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("sb_wb_valid", 64'(wb_valid), 64'd1);
    chk("sb_wb_wreg", 64'(wb_wreg), 64'd0);
    chk("sb_req", 64'(mem_bus.mem_req), 64'd1);
    chk("sb_we", 64'(mem_bus.mem_we), 64'd1);
    chk("sb_addr", 64'(mem_bus.mem_addr), 64'h1000);
    chk("sb_be", 64'(mem_bus.mem_be), 64'h8);
    chk("sb_wdata", 64'(mem_bus.mem_wdata), 64'hAB00_0000);
    tick();
    @(negedge clk);
    chk("sb_hold_addr", 64'(mem_bus.mem_addr), 64'h1000);
    chk("sb_hold_data", 64'(mem_bus.mem_wdata), 64'hAB00_0000);
    tick();
    mem_bus.mem_gnt = 1'b1;
    tick();
    mem_bus.mem_gnt = 1'b0;
    @(negedge clk);
    chk("sb_popped", 64'(mem_bus.mem_req), 64'd0);

    // Byte loads with sign and zero extension
    load_seq("lb", 4'd1, 32'h2002, 5'd6, 32'h0080_0000, 32'hFFFF_FF80);
    load_seq("lbu", 4'd4, 32'h2002, 5'd6, 32'h0080_0000, 32'h0000_0080);
    load_seq("lh_hi", 4'd2, 32'h2002, 5'd8, 32'h8001_0000, 32'hFFFF_8001);

    // Two stores fill the buffer; a third stalls; the load waits for the drain
    tick();
    drive(1'b1, 4'd11, 5'd0, 1'b0, 32'h10, 32'h1111_1111);
    @(negedge clk);
    chk("sw1_ready", 64'(ex_ready), 64'd1);
    tick();
    drive(1'b1, 4'd11, 5'd0, 1'b0, 32'h14, 32'h2222_2222);
    @(negedge clk);
    chk("sw2_ready", 64'(ex_ready), 64'd1);
    tick();
    drive(1'b1, 4'd11, 5'd0, 1'b0, 32'h18, 32'h3333_3333);
    @(negedge clk);
    chk("sw3_full_ready", 64'(ex_ready), 64'd0);
    chk("sw3_stall", 64'(stall_req), 64'd1);
    tick();
    drive(1'b1, 4'd3, 5'd7, 1'b1, 32'h20, 32'h0);
    @(negedge clk);
    chk("lw_ready", 64'(ex_ready), 64'd1);
    tick();
    drive(1'b0, 4'd0, 5'd0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("lw_pend_busy", 64'(ex_ready), 64'd0);
    chk("lw_pend_store_we", 64'(mem_bus.mem_we), 64'd1);
    chk("lw_pend_store_addr", 64'(mem_bus.mem_addr), 64'h10);
    tick();
    mem_bus.mem_gnt = 1'b1;
    @(negedge clk);
    chk("drain1_addr", 64'(mem_bus.mem_addr), 64'h10);
    chk("drain1_data", 64'(mem_bus.mem_wdata), 64'h1111_1111);
    chk("drain1_be", 64'(mem_bus.mem_be), 64'hF);
    tick();
    @(negedge clk);
    chk("drain2_we", 64'(mem_bus.mem_we), 64'd1);
    chk("drain2_addr", 64'(mem_bus.mem_addr), 64'h14);
    chk("drain2_data", 64'(mem_bus.mem_wdata), 64'h2222_2222);
    tick();
    mem_bus.mem_gnt = 1'b0;
    @(negedge clk);
    chk("drained_idle", 64'(mem_bus.mem_req), 64'd0);
    finish_load("lw", 32'h20, 5'd7, 32'hCAFE_BABE, 32'hCAFE_BABE);

    // Misaligned halfword and RV64-only op both fault without a request
    tick();
    drive(1'b1, 4'd2, 5'd3, 1'b1, 32'h3001, 32'h0);
    @(negedge clk);
    chk("lh_mis_ready", 64'(ex_ready), 64'd1);
    tick();
    drive(1'b0, 4'd0, 5'd0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("lh_mis_err", 64'(err_o), 64'd1);
    chk("lh_mis_err_addr", 64'(err_addr), 64'h3001);
    chk("lh_mis_wb_valid", 64'(wb_valid), 64'd1);
    chk("lh_mis_wb_wreg", 64'(wb_wreg), 64'd0);
    chk("lh_mis_noreq", 64'(mem_bus.mem_req), 64'd0);
    tick();
    drive(1'b1, 4'd6, 5'd4, 1'b1, 32'h4000, 32'h0);
    @(negedge clk);
    chk("err_pulse", 64'(err_o), 64'd0);
    tick();
    drive(1'b0, 4'd0, 5'd0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("ld32_err", 64'(err_o), 64'd1);
    chk("ld32_err_addr", 64'(err_addr), 64'h4000);
    chk("ld32_noreq", 64'(mem_bus.mem_req), 64'd0);
    chk("ld32_ready", 64'(ex_ready), 64'd1);

    // Reset discards a pending store
    tick();
    drive(1'b1, 4'd11, 5'd0, 1'b0, 32'h60, 32'h6666_6666);
    tick();
    drive(1'b0, 4'd0, 5'd0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("sw_pending_req", 64'(mem_bus.mem_req), 64'd1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_sb_empty", 64'(mem_bus.mem_req), 64'd0);

    // Reset in LD_WAIT, then a stale rvalid must not retire anything
    tick();
    drive(1'b1, 4'd3, 5'd9, 1'b1, 32'h70, 32'h0);
    tick();
    drive(1'b0, 4'd0, 5'd0, 1'b0, 32'h0, 32'h0);
    begin
      logic found;
      found = 1'b0;
      for (int i = 0; i < 12 && !found; i++) begin
        @(negedge clk);
        if (mem_bus.mem_req && !mem_bus.mem_we) found = 1'b1;
      end
      chk("rstld_req_seen", 64'(found), 64'd1);
    end
    mem_bus.mem_gnt = 1'b1;
    tick();
    mem_bus.mem_gnt = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("rstld_waiting", 64'(ex_ready), 64'd0);
    tick();
    rst = 1'b0;
    mem_bus.mem_rvalid = 1'b1;
    mem_bus.mem_rdata  = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("rstld_ready", 64'(ex_ready), 64'd1);
    chk("rstld_noreq", 64'(mem_bus.mem_req), 64'd0);
    tick();
    mem_bus.mem_rvalid = 1'b0;
    @(negedge clk);
    chk("rstld_no_wb", 64'(wb_valid), 64'd0);
    chk("rstld_ready2", 64'(ex_ready), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
